// File: rtl/aes_decipher_ctrl_pkg.sv
// aes_decipher_ctrl_pkg: shared round/state encodings, round counts and GF(2^8) helpers.
package aes_decipher_ctrl_pkg;
  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;
  typedef enum logic [1:0] {RT_INIT = 2'd0, RT_MAIN = 2'd1, RT_FINAL = 2'd2} round_type_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_MAIN = 2'd2, S_FINAL = 2'd3} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int k = 0; k < 8; k++) begin
      r = r ^ (b[k] ? p : 8'h00);
      p = xtime(p);
    end
    return r;
  endfunction
  // Undo the affine map, then invert in GF(2^8) as x^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
endpackage

// File: rtl/aes_decipher_ctrl_if.sv
// aes_decipher_ctrl_if: core-side handshake plus key-memory request/response.
interface aes_decipher_ctrl_if;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic [127:0] round_key;
  logic [3:0]   round_nr;
  logic         ready;
  logic         result_valid;
  logic [127:0] result;
  modport slave (input next, keylen, block, round_key, output round_nr, ready, result_valid, result);
  modport master (output next, keylen, block, round_key, input round_nr, ready, result_valid, result);
endinterface

// File: rtl/aes_decipher_ctrl_round.sv
// aes_decipher_round: one combinational AES inverse round selected by round type.
module aes_decipher_round
  import aes_decipher_ctrl_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  round_type_e  type_i,
  output logic [127:0] state_o
);
  logic [7:0] in_b [16];
  logic [7:0] sb   [16];
  logic [7:0] ak   [16];
  logic [7:0] mc   [16];
  // Byte i sits at row i%4, column i/4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R = i % 4;
    localparam int C = i / 4;
    assign in_b[i] = state_i[127-8*i -: 8];
    assign sb[i]   = inv_sbox(in_b[R + 4*((C - R + 4) % 4)]);
    assign ak[i]   = (type_i == RT_INIT ? in_b[i] : sb[i]) ^ key_i[127-8*i -: 8];
    assign mc[i]   = gmul(ak[4*C + R], 8'h0e) ^ gmul(ak[4*C + (R+1)%4], 8'h0b) ^
                     gmul(ak[4*C + (R+2)%4], 8'h0d) ^ gmul(ak[4*C + (R+3)%4], 8'h09);
    assign state_o[127-8*i -: 8] = type_i == RT_MAIN ? mc[i] : ak[i];
  end
endmodule

// File: rtl/aes_decipher_ctrl.sv
// aes_decipher_ctrl: iterative AES-128/256 decipher, one round per clock.
module aes_decipher_ctrl
  import aes_decipher_ctrl_pkg::*;
(
  input logic clk,
  input logic reset_n,
  aes_decipher_ctrl_if.slave bus
);
  state_e       state_q, state_d;
  logic [127:0] block_q, block_d, round_out;
  logic [3:0]   ctr_q, ctr_d;
  logic         valid_q, valid_d;
  round_type_e  rtype;
  aes_decipher_round u_round (
    .state_i (block_q),
    .key_i   (bus.round_key),
    .type_i  (rtype),
    .state_o (round_out)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      block_q <= '0;
      ctr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      ctr_q   <= ctr_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    ctr_d   = ctr_q;
    valid_d = valid_q;
    rtype   = state_q == S_MAIN ? RT_MAIN : state_q == S_FINAL ? RT_FINAL : RT_INIT;
    case (state_q)
      S_IDLE: if (bus.next) begin
        block_d = bus.block;
        ctr_d   = bus.keylen ? AES256_ROUNDS : AES128_ROUNDS;
        valid_d = 1'b0;
        state_d = S_INIT;
      end
      S_INIT: begin
        block_d = round_out;
        ctr_d   = ctr_q - 4'd1;
        state_d = S_MAIN;
      end
      S_MAIN: begin
        block_d = round_out;
        ctr_d   = ctr_q - 4'd1;
        state_d = ctr_q == 4'd1 ? S_FINAL : S_MAIN;
      end
      default: begin
        block_d = round_out;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  assign bus.round_nr     = ctr_q;
  assign bus.ready        = state_q == S_IDLE;
  assign bus.result_valid = valid_q;
  assign bus.result       = block_q;
endmodule

// File: doc/aes_decipher_ctrl.md
Name: aes_decipher_ctrl

Overview:
Iterative AES decipher controller. It owns the 128-bit block state register and instantiates one aes_decipher_round, running one round per clock. For each round it supplies the round_type and requests a round key by index from the external key memory. It sits between the AES core top (block/next/ready handshake) and the key expansion memory, and supports AES-128 (10 rounds) and AES-256 (14 rounds).

Parameters:
AES128_ROUNDS, 10, main+final round count for keylen=0
AES256_ROUNDS, 14, main+final round count for keylen=1

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
next  in  1  start pulse; sampled only while ready=1
keylen  in  1  0=AES-128, 1=AES-256; sampled with next
block  in  128  ciphertext; sampled with next
round_key  in  128  key for round_nr, combinational from key memory, valid same cycle
round_nr  out  4  round key index currently requested
ready  out  1  1=idle, can accept next
result_valid  out  1  result holds plaintext of last completed operation
result  out  128  block state register

Behaviour:
- Reset (async, reset_n=0): state=IDLE, block_reg=0, round_ctr=0, ready=1, result_valid=0. Reset mid-operation aborts it with no partial result flagged.
- Byte mapping: block byte i (bits 127-8i..120-8i) maps to s[i%4][i/4], column-major per FIPS-197. Round outputs map back the same way into block_reg.
- Round types (shared constants): INIT=0 (AddRoundKey only), MAIN=1 (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), FINAL=2 (InvShiftRows, InvSubBytes, AddRoundKey).
- States: IDLE, INIT, MAIN, FINAL. round_type follows the state; it is INIT in IDLE, and its output is unused there.
- IDLE with next=1:
  - block_reg<=block.
  - round_ctr<=10 or 14 according to keylen.
  - ready<=0, result_valid<=0, state<=INIT.
- IDLE with next=0: hold all registers.
- INIT edge: block_reg<=round output, round_ctr<=round_ctr-1, state<=MAIN.
- MAIN edge: block_reg<=round output.
  - If round_ctr==1: round_ctr<=0, state<=FINAL.
  - Otherwise: round_ctr<=round_ctr-1.
- FINAL edge: block_reg<=round output, state<=IDLE, ready<=1, result_valid<=1.
- round_nr = round_ctr, combinational. Sequence: AES-128 10,9..1,0; AES-256 14..0.
- Latency:
  - Sampling edge E; ready and result_valid high after edge E+11 (AES-128) or E+15 (AES-256).
  - Busy cycles: 11 or 15.
- next while ready=0 is ignored, including on the FINAL cycle. A new start is possible on the first cycle ready=1 (back-to-back).
- keylen and block changes while busy have no effect.
- result is stable and equals block_reg whenever ready=1. It is not cleared until the next accepted start (result_valid drops on the edge after acceptance).
- round_ctr is 4 bits; it never underflows because FINAL does not decrement.

Decomposition:
- Shared package: round type constants INIT/MAIN/FINAL (2-bit), AES128_ROUNDS/AES256_ROUNDS, and the state encoding for IDLE/INIT/MAIN/FINAL (2-bit).
- One sub-module: aes_decipher_round, instantiated once and driven by the controller's block_reg bytes, round_type and round_key.
- Controller contains only the FSM, the counter and block_reg.

Test Plan:
- AES-128 vector: key 000102030405060708090a0b0c0d0e0f (bench key-memory model holds the expanded keys), block 69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, next pulse -> after 11 busy cycles result=00112233445566778899aabbccddeeff, result_valid=1, ready=1.
- AES-256 vector: key 000102...1e1f, block 8ea2b7ca516745bfeafc49904b496089, keylen=1 -> after 15 cycles result=00112233445566778899aabbccddeeff.
- round_nr trace during the AES-128 run -> exactly 10,9,8,...,1,0, one per cycle; round_type INIT, MAIN x9, FINAL.
- next held high and block changed during the busy period -> no restart, result unchanged from the correct plaintext. With next still high on the first ready cycle, the second operation starts immediately.
- reset_n low at busy cycle 5, then released -> ready=1, result_valid=0, result=0 immediately. A subsequent normal AES-128 run is correct.
- Back-to-back AES-128 then AES-256 starts (next on the first ready cycle) -> both results correct; result_valid deasserts for the duration of the second run.
